// File: rtl/pwl_exp.sv
// pwl_exp: piecewise-linear exp/antilog approximation, y = a[s]*x + (b[s] <<< 16).
// The operand x is Q16.16. The result y is a full Q32.32 product-plus-offset.
// The segment index s is found by a sequential search, one compare per cycle.
// The two coefficient tables (slope a, offset b) are written through the coef_* port.
// The port only writes while the block is idle.
// Optional feature: define PWL_EXP_SAT_EN to saturate y when x >= K*1.0.
// Without it, the last segment is extrapolated linearly.
module pwl_exp #(
    parameter int K = 7,
    parameter int N = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N:0]     x,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N+1:0] y,
    output logic           out_sat,
    input  logic           coef_we,
    input  logic           coef_sel,
    input  logic [2:0]     coef_addr,
    input  logic [31:0]    coef_wdata
);

    localparam int         YW       = 2*N + 2;
    localparam logic [3:0] SEG_LAST = 4'(K - 1);
    localparam logic [3:0] SEG_CNT  = 4'(K);

    typedef enum logic [1:0] {IDLE, SEARCH, MAC, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            s;
    logic signed [N:0]     x_r;
    logic signed [YW-1:0]  y_r;
    logic signed [31:0]    coef_a [K];
    logic signed [31:0]    coef_b [K];
    logic                  search_up;
    logic                  coef_ok;

    // Integer boundary idx*1.0 in Q16.16, one bit wider than x so K*1.0 never overflows.
    function automatic logic signed [N+1:0] seg_base(input logic [3:0] idx);
        seg_base = $signed({{(N-18){1'b0}}, idx, 16'h0000});
    endfunction

    // Exact signed multiply-add: Q16.16 * Q16.16 gives Q32.32, and the offset is aligned by 16.
    function automatic logic signed [YW-1:0] mac(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input logic signed [N:0]  xv);
        logic signed [YW-1:0] a_w;
        logic signed [YW-1:0] b_w;
        logic signed [YW-1:0] x_w;
        a_w = {{(YW-32){a[31]}}, a};
        b_w = {{(YW-32){b[31]}}, b};
        x_w = {{(N+1){xv[N]}}, xv};
        mac = a_w * x_w + (b_w <<< 16);
    endfunction

`ifdef PWL_EXP_SAT_EN
    logic sat_r;

    // True when the operand lies beyond the last segment's range.
    function automatic logic over_range(input logic signed [N:0] xv);
        over_range = $signed({xv[N], xv}) >= seg_base(SEG_CNT);
    endfunction

    // Clamp to the largest positive Q32.32 value when out of range.
    function automatic logic signed [YW-1:0] saturate(input logic signed [YW-1:0] raw,
                                                      input logic over);
        saturate = over ? {1'b0, {(YW-1){1'b1}}} : raw;
    endfunction
`endif

    // Advance the segment while another step fits below x and a higher segment exists.
    assign search_up = ({1'b0, s} < SEG_LAST) &&
                       ($signed({x_r[N], x_r}) >= seg_base({1'b0, s} + 4'd1));
    assign coef_ok   = ({1'b0, coef_addr} < SEG_CNT);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic. DONE always returns through IDLE before taking a new operand.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SEARCH;
            SEARCH:  if (!search_up) state_nxt = MAC;
            MAC:                     state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Operand capture, segment search counter, and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= '0;
            x_r <= '0;
            y_r <= '0;
`ifdef PWL_EXP_SAT_EN
            sat_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r <= x;
                        s   <= '0;
                    end
                end
                SEARCH: begin
                    if (search_up) s <= s + 3'd1;
                end
                MAC: begin
`ifdef PWL_EXP_SAT_EN
                    y_r   <= saturate(mac(coef_a[s], coef_b[s], x_r), over_range(x_r));
                    sat_r <= over_range(x_r);
`else
                    y_r   <= mac(coef_a[s], coef_b[s], x_r);
`endif
                end
                default: ;
            endcase
        end
    end

    // Coefficient tables. They only accept writes while idle, so a running operation never sees a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                coef_a[i] <= '0;
                coef_b[i] <= '0;
            end
        end else if (state == IDLE && coef_we && coef_ok) begin
            if (coef_sel) coef_b[coef_addr] <= coef_wdata;
            else          coef_a[coef_addr] <= coef_wdata;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign y         = y_r;
`ifdef PWL_EXP_SAT_EN
    assign out_sat   = sat_r;
`else
    assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_pwl_exp.sv
// tb_pwl_exp: directed-vector bench for pwl_exp with hand-computed expected results.
// Honors PWL_EXP_SAT_EN the same way the design does.
module tb_pwl_exp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] y;
    logic        out_sat;
    logic        coef_we = 1'b0;
    logic        coef_sel = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [31:0] coef_wdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PWL_EXP_SAT_EN
    localparam logic [63:0] Y_X8 = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic        S_X8 = 1'b1;
    localparam logic [63:0] Y_X7 = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic        S_X7 = 1'b1;
`else
    localparam logic [63:0] Y_X8 = 64'h0000_0008_0000_0000;
    localparam logic        S_X8 = 1'b0;
    localparam logic [63:0] Y_X7 = 64'h0000_0007_0000_0000;
    localparam logic        S_X7 = 1'b0;
`endif

    always #5 clk = ~clk;

    pwl_exp dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .out_sat    (out_sat),
        .coef_we    (coef_we),
        .coef_sel   (coef_sel),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic sel, input logic [2:0] addr, input logic [31:0] data);
        coef_we    = 1'b1;
        coef_sel   = sel;
        coef_addr  = addr;
        coef_wdata = data;
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic start_op(input logic [31:0] xv);
        x        = xv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [63:0] ey, input logic es);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_y"}, y, ey);
        check({tag, "_sat"}, {63'd0, out_sat}, {63'd0, es});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit hit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xs   [4];
        int          lats [4];
        logic [63:0] ys   [4];
        int          vcnt;
        int          done_cnt;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_y", y, 64'd0);
        check("rst_sat", {63'd0, out_sat}, 64'd0);

        // 2.5 in segment 2: 2*2.5 + 1 = 6.0
        write_coef(1'b0, 3'd2, 32'h0002_0000);
        write_coef(1'b1, 3'd2, 32'h0001_0000);
        check("pre_op_ready", {63'd0, in_ready}, 64'd1);
        start_op(32'h0002_8000);
        wait_done("seg2", 4, 64'h0000_0006_0000_0000, 1'b0);
        release_out("seg2");

        // Negative x falls in segment 0: 1*(-1.0) = -1.0
        write_coef(1'b0, 3'd0, 32'h0001_0000);
        start_op(32'hFFFF_0000);
        wait_done("neg", 2, 64'hFFFF_FFFF_0000_0000, 1'b0);
        release_out("neg");

        // Most negative operand: 1*(-32768.0) = -2^47 in Q32.32
        start_op(32'h8000_0000);
        wait_done("minx", 2, 64'hFFFF_8000_0000_0000, 1'b0);
        release_out("minx");

        // Top segment and the range boundary at 7.0
        write_coef(1'b0, 3'd6, 32'h0001_0000);
        start_op(32'h0008_0000);
        wait_done("x8", 8, Y_X8, S_X8);
        release_out("x8");
        start_op(32'h0007_0000);
        wait_done("x7", 8, Y_X7, S_X7);
        release_out("x7");
        start_op(32'h0006_FFFF);
        wait_done("x7m", 8, 64'h0000_0006_FFFF_0000, 1'b0);
        release_out("x7m");

        // Exact boundary 1.0 selects segment 1; hold the result for 5 cycles, and a write then is dropped
        write_coef(1'b0, 3'd1, 32'h0001_0000);
        start_op(32'h0001_0000);
        wait_done("hold", 3, 64'h0000_0001_0000_0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                coef_we    = 1'b1;
                coef_sel   = 1'b0;
                coef_addr  = 3'd1;
                coef_wdata = 32'h0005_0000;
            end
            tick();
            coef_we = 1'b0;
            check("hold_y", y, 64'h0000_0001_0000_0000);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_ready", {63'd0, in_ready}, 64'd0);
        end
        release_out("hold");
        write_coef(1'b0, 3'd7, 32'h0009_0000);
        start_op(32'h0001_0000);
        wait_done("hold_tbl", 3, 64'h0000_0001_0000_0000, 1'b0);
        release_out("hold_tbl");

        // Coefficient write together with the operand: the new slope applies. 3*3.0 = 9.0
        coef_we    = 1'b1;
        coef_sel   = 1'b0;
        coef_addr  = 3'd3;
        coef_wdata = 32'h0003_0000;
        start_op(32'h0003_0000);
        coef_we = 1'b0;
        wait_done("same_cyc", 5, 64'h0000_0009_0000_0000, 1'b0);
        release_out("same_cyc");

        // Reset during SEARCH aborts the operation
        start_op(32'h0005_0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {63'd0, in_ready}, 64'd1);
        check("abort_y", y, 64'd0);
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) vcnt++;
        end
        check("abort_no_pulse", 64'(vcnt), 64'd0);

        // Reset wins over a handshake and a coefficient write in the same cycle
        rst        = 1'b1;
        in_valid   = 1'b1;
        x          = 32'h0001_0000;
        coef_we    = 1'b1;
        coef_sel   = 1'b0;
        coef_addr  = 3'd0;
        coef_wdata = 32'h0001_0000;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        check("rst_prio_ready", {63'd0, in_ready}, 64'd1);
        start_op(32'h0000_8000);
        wait_done("rst_prio_tbl", 2, 64'd0, 1'b0);
        release_out("rst_prio_tbl");

        // Back-to-back operands with out_ready tied high
        write_coef(1'b0, 3'd0, 32'h0001_0000);
        write_coef(1'b0, 3'd1, 32'h0001_0000);
        write_coef(1'b0, 3'd4, 32'h0001_0000);
        xs[0] = 32'h0000_8000; lats[0] = 2; ys[0] = 64'h0000_0000_8000_0000;
        xs[1] = 32'h0001_8000; lats[1] = 3; ys[1] = 64'h0000_0001_8000_0000;
        xs[2] = 32'h0004_8000; lats[2] = 6; ys[2] = 64'h0000_0004_8000_0000;
        xs[3] = 32'hFFFF_8000; lats[3] = 2; ys[3] = 64'hFFFF_FFFF_8000_0000;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        done_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            x = xs[i];
            check("b2b_ready", {63'd0, in_ready}, 64'd1);
            tick();
            x = 32'h7FFF_0000;
            begin
                int n;
                n = 0;
                while (!out_valid && n < 30) begin
                    tick();
                    n++;
                end
                check("b2b_lat", 64'(n), 64'(lats[i]));
                check("b2b_y", y, ys[i]);
                if (out_valid) done_cnt++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 64'(done_cnt), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwl_exp.md
PWL_EXP -- requirements
Module: pwl_exp

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high, with ports named clk and rst.
REQ-002 Ports SHALL be as follows, in this order:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: operand x valid.
- in_ready, out, 1: block can accept an operand.
- x, in, 32: signed operand, Q16.16.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- y, out, 64: signed result, Q32.32.
- out_sat, out, 1: result saturated.
- coef_we, in, 1: coefficient write strobe.
- coef_sel, in, 1: selects the table (0 = slope a, 1 = offset b).
- coef_addr, in, 3: segment index, 0..6.
- coef_wdata, in, 32: signed coefficient, Q16.16.
REQ-003 Parameter K SHALL default to 7 and sets the number of segments; parameter N SHALL default to 31 and is the MSB index of x.

Function
REQ-004 The block SHALL compute a piecewise-linear antilog/exp approximation, y = a[s]*x + (b[s] <<< 16), as a full signed 64-bit result with no truncation.
REQ-005 Segment s SHALL be the largest value in 0..K-1 such that x >= s*65536; any x < 65536, including negative x, SHALL give s = 0.
REQ-006 The FSM SHALL have four states: IDLE, SEARCH, MAC and DONE.
REQ-007 in_ready SHALL be 1 only in IDLE.
REQ-008 In IDLE, when in_valid=1, the block SHALL register x, clear s to 0 and go to SEARCH.
REQ-009 SEARCH SHALL perform one compare per cycle: if s < K-1 and x >= (s+1)*65536, then s <= s+1 and the FSM stays in SEARCH; otherwise it goes to MAC.
REQ-010 MAC SHALL register y from a[s], b[s] and the registered x, then go to DONE.
REQ-011 out_valid SHALL be 1 only in DONE; y and out_sat SHALL hold stable while out_valid=1 and out_ready=0.
REQ-012 In DONE, out_ready=1 SHALL return the FSM to IDLE; a new operand SHALL NOT be accepted in that same cycle.
REQ-013 out_valid SHALL rise exactly s+2 clock edges after the accepting edge.
REQ-014 in_valid and x SHALL be ignored outside IDLE.
REQ-015 A coefficient write (coef_we=1) SHALL update table coef_sel at entry coef_addr on the next edge, and only when the FSM is in IDLE; writes in any other state SHALL be dropped.
REQ-016 A write with coef_addr=7 SHALL be dropped.
REQ-017 When coef_we and in_valid are both high in IDLE, both SHALL take effect, and the new coefficient SHALL be used by that operation.

Reset
REQ-018 rst=1 at any clock edge SHALL force the FSM to IDLE and clear s, the registered x, y, out_valid, out_sat and all 14 coefficient registers to 0.
REQ-019 After reset, in_ready SHALL be 1.
REQ-020 Reset during SEARCH, MAC or DONE SHALL abort the operation with no out_valid pulse.
REQ-021 Reset SHALL take priority over all handshakes and writes in the same cycle.

Configuration
REQ-022 Macro PWL_EXP_SAT_EN SHALL control output saturation.
REQ-023 With PWL_EXP_SAT_EN defined, a registered x >= K*65536 SHALL produce y = 64'h7FFF_FFFF_FFFF_FFFF and out_sat=1 in MAC, with SEARCH timing unchanged.
REQ-024 With PWL_EXP_SAT_EN undefined, segment K-1 SHALL be extrapolated linearly, and out_sat SHALL be tied to 0.

Verification
REQ-025 Reset, then write a[2]=0x00020000 and b[2]=0x00010000, then present x=0x00028000 -> accepted in IDLE; out_valid rises 4 edges later; y=0x0000_0006_0000_0000; out_sat=0.
REQ-026 Write a[0]=0x00010000, present x=0xFFFF0000 (-1.0) -> s=0; out_valid rises after 2 edges; y=0xFFFF_FFFF_0000_0000.
REQ-027 Write a[6]=0x00010000, present x=0x00080000 -> with the macro: y=0x7FFF_FFFF_FFFF_FFFF and out_sat=1 after 8 edges; without the macro: y=0x0000_0008_0000_0000 and out_sat=0.
REQ-028 Hold out_ready=0 for 5 cycles in DONE -> y stable, out_valid held, in_ready=0; a coef_we pulse during this time leaves the tables unchanged.
REQ-029 Assert rst during SEARCH for x=0x00050000 -> next cycle the FSM is in IDLE, in_ready=1, y=0, and no out_valid pulse occurs.
REQ-030 Issue back-to-back operands with out_ready tied to 1 -> each operation takes s+3 cycles in DONE/IDLE turnaround and no operand is lost.
